// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
// Sequencer for an external 8-bit ripple-carry adder. It accepts one operand
// request and holds the operands on ain/bin/cin for a full evaluation cycle.
// It registers the adder result and presents it through a valid/ready
// handshake. The carry of an accepted result is kept so that the next
// request can chain it, which supports multi-byte additions.
//
// Optional feature: define ADD_SEQ_OVF_EN to add out_ovf. This is the signed
// overflow flag, and it is registered together with out_sum.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a request; operands captured on accept
// EXEC  | adder evaluating the captured operands; result registered at exit
// DONE  | out_valid=1, result held until out_ready; carry chained on accept

module add_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_first,
  output logic [7:0] ain,
  output logic [7:0] bin,
  output logic       cin,
  input  logic [7:0] sum,
  input  logic       cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
`ifdef ADD_SEQ_OVF_EN
  output logic       out_carry,
  output logic       out_ovf
`else
  output logic       out_carry
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       capture;
  logic       finish;
  logic       handshake;

  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic       cin_reg;
  logic       carry_reg;

  // The adder only ever sees the captured registers. The operands therefore
  // stay stable for the whole transaction, whatever happens on in_a/in_b.
  assign ain = a_reg;
  assign bin = b_reg;
  assign cin = cin_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        finish    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture. A first byte starts a new chain with carry-in 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      cin_reg <= 1'b0;
    end else if (capture) begin
      a_reg   <= in_a;
      b_reg   <= in_b;
      cin_reg <= in_first ? 1'b0 : carry_reg;
    end
  end

  // Result register, loaded at the closing edge of EXEC and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sum   <= 8'h00;
      out_carry <= 1'b0;
    end else if (finish) begin
      out_sum   <= sum;
      out_carry <= cout;
    end
  end

`ifdef ADD_SEQ_OVF_EN
  // Signed overflow: the operands share a sign and the sum's sign differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (finish) begin
      out_ovf <= (a_reg[7] == b_reg[7]) && (sum[7] != a_reg[7]);
    end
  end
`endif

  // Chained carry. It moves only when the consumer takes the result, so a
  // result that was dropped by reset never leaks into the next byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_reg <= 1'b0;
    end else if (handshake) begin
      carry_reg <= out_carry;
    end
  end

endmodule
